// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared types for the RV32I pipeline hazard logic.
// Forward-select codes, sequencer states and the shadow stage record.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b10;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b00;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
    logic       is_mem;
  } shadow_t;

endpackage

// File: rtl/riscv_hazard_controller_if.sv
// riscv_hazard_controller_if: pipeline <-> hazard sequencer bundle.
// Perf counter wires exist only with HAZARD_PERF_CNT_EN defined.
interface riscv_hazard_controller_if;

  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       id_is_mem;
  logic       ex_branch_taken;
  logic       dmem_ready;

  logic       stall_if;
  logic       stall_id;
  logic       stall_ex;
  logic       stall_mem;
  logic       bubble_ex;
  logic       flush_if_id;
  logic       bubble_wb;
  logic [1:0] forwardA;
  logic [1:0] forwardB;
  logic       mem_timeout_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stalls;
  logic [31:0] perf_mem_wait_cycles;
  logic [31:0] perf_flushes;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd,
    output id_regwrite, id_is_load, id_is_mem,
    output ex_branch_taken, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
    input  perf_lu_stalls, perf_mem_wait_cycles,
    input  perf_flushes,
`endif
    input  stall_if, stall_id, stall_ex, stall_mem,
    input  bubble_ex, flush_if_id, bubble_wb,
    input  forwardA, forwardB, mem_timeout_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd,
    input  id_regwrite, id_is_load, id_is_mem,
    input  ex_branch_taken, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
    output perf_lu_stalls, perf_mem_wait_cycles,
    output perf_flushes,
`endif
    output stall_if, stall_id, stall_ex, stall_mem,
    output bubble_ex, flush_if_id, bubble_wb,
    output forwardA, forwardB, mem_timeout_err
  );

endinterface

// File: rtl/riscv_fwd_select.sv
// riscv_fwd_select: EX operand bypass select for one source register.
// MEM result wins over WB result; x0 never bypasses.
module riscv_fwd_select
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic       i_mem_fwd,
  input  logic [4:0] i_mem_rd,
  input  logic       i_wb_fwd,
  input  logic [4:0] i_wb_rd,
  output logic [1:0] o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_fwd
                   & (i_mem_rd != 5'd0)
                   & (i_mem_rd == i_rs);
  assign w_wb_hit  = i_wb_fwd
                   & (i_wb_rd != 5'd0)
                   & (i_wb_rd == i_rs)
                   & ~w_mem_hit;

  always_comb begin
    o_sel = FWD_REGFILE;
    unique case (1'b1)
      w_mem_hit: o_sel = FWD_MEM;
      w_wb_hit:  o_sel = FWD_WB;
      default:   o_sel = FWD_REGFILE;
    endcase
  end

endmodule

// File: rtl/riscv_hazard_controller.sv
// riscv_hazard_controller: stall/flush/forward sequencer for 5-stage RV32I.
// Define HAZARD_PERF_CNT_EN to add the three 32-bit perf counters.
module riscv_hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  riscv_hazard_controller_if.slave hz
);

  shadow_t          r_ex;
  shadow_t          r_mem;
  shadow_t          r_wb;
  shadow_t          w_id;
  hz_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_err;

  logic       w_load_use;
  logic       w_mem_wait;
  logic       w_br_act;
  logic       w_lu_act;
  logic       w_stall_fe;
  logic       w_freeze;
  logic       w_bex;
  logic       w_mem_fwd;
  logic       w_wb_fwd;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_unused;

  assign w_id = '{
    valid:    hz.id_valid,
    rs1:      hz.id_rs1,
    rs2:      hz.id_rs2,
    rd:       hz.id_rd,
    regwrite: hz.id_regwrite,
    is_load:  hz.id_is_load,
    is_mem:   hz.id_is_mem
  };

  assign w_load_use = r_ex.valid & r_ex.is_load
                    & r_ex.regwrite
                    & (r_ex.rd != 5'd0)
                    & hz.id_valid
                    & ((r_ex.rd == hz.id_rs1)
                     | (r_ex.rd == hz.id_rs2));

  assign w_mem_wait = r_mem.valid & r_mem.is_mem
                    & ~hz.dmem_ready;

  // Memory freeze outranks branch, branch outranks load-use.
  assign w_br_act = hz.ex_branch_taken & ~w_mem_wait;
  assign w_lu_act = w_load_use & ~hz.ex_branch_taken
                  & ~w_mem_wait;

  always_comb begin
    w_stall_fe = 1'b0;
    w_freeze   = 1'b0;
    w_bex      = 1'b0;
    unique case (1'b1)
      w_mem_wait: begin
        w_stall_fe = 1'b1;
        w_freeze   = 1'b1;
      end
      w_br_act: w_bex = 1'b1;
      w_lu_act: begin
        w_stall_fe = 1'b1;
        w_bex      = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz.stall_if        = w_stall_fe;
  assign hz.stall_id        = w_stall_fe;
  assign hz.stall_ex        = w_freeze;
  assign hz.stall_mem       = w_freeze;
  assign hz.bubble_wb       = w_freeze;
  assign hz.bubble_ex       = w_bex;
  assign hz.flush_if_id     = w_br_act;
  assign hz.mem_timeout_err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (w_mem_wait) begin
      r_wb <= '0;
    end else begin
      r_ex  <= w_bex ? '0 : w_id;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign w_mem_fwd = r_mem.valid & r_mem.regwrite
                   & ~r_mem.is_load;
  assign w_wb_fwd  = r_wb.valid & r_wb.regwrite;
  assign w_unused  = ^{r_wb.rs1, r_wb.rs2,
                       r_wb.is_load, r_wb.is_mem};

  riscv_fwd_select u_fwd_a (
    .i_rs      (r_ex.rs1),
    .i_mem_fwd (w_mem_fwd),
    .i_mem_rd  (r_mem.rd),
    .i_wb_fwd  (w_wb_fwd),
    .i_wb_rd   (r_wb.rd),
    .o_sel     (w_fwd_a)
  );

  riscv_fwd_select u_fwd_b (
    .i_rs      (r_ex.rs2),
    .i_mem_fwd (w_mem_fwd),
    .i_mem_rd  (r_mem.rd),
    .i_wb_fwd  (w_wb_fwd),
    .i_wb_rd   (r_wb.rd),
    .o_sel     (w_fwd_b)
  );

  assign hz.forwardA = w_fwd_a;
  assign hz.forwardB = w_fwd_b;

  assign w_cnt_nxt = (r_cnt == '1) ? r_cnt
                                   : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mem_wait) begin
            r_state <= MEM_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!w_mem_wait) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt >= CNT_W'(MEM_TIMEOUT))
              r_err <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_pf_lu;
  logic [31:0] r_pf_mw;
  logic [31:0] r_pf_fl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pf_lu <= '0;
      r_pf_mw <= '0;
      r_pf_fl <= '0;
    end else begin
      if (w_lu_act)   r_pf_lu <= r_pf_lu + 32'd1;
      if (w_mem_wait) r_pf_mw <= r_pf_mw + 32'd1;
      if (w_br_act)   r_pf_fl <= r_pf_fl + 32'd1;
    end
  end

  assign hz.perf_lu_stalls       = r_pf_lu;
  assign hz.perf_mem_wait_cycles = r_pf_mw;
  assign hz.perf_flushes         = r_pf_fl;
`endif

endmodule

// File: tb/tb_riscv_hazard_controller.sv
// tb_riscv_hazard_controller: scoreboard bench for the hazard sequencer.
// Built with MEM_TIMEOUT=4 so the timeout path is reachable quickly.
module tb_riscv_hazard_controller;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  riscv_hazard_controller_if hz_if ();

  riscv_hazard_controller #(
    .MEM_TIMEOUT (4),
    .CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  typedef struct {
    string      nm;
    logic [6:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] err;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // ctl = {stall_if, stall_id, stall_ex, stall_mem,
  //        bubble_ex, flush_if_id, bubble_wb}
  localparam logic [6:0] C_0  = 7'b0000000;
  localparam logic [6:0] C_LU = 7'b1100100;
  localparam logic [6:0] C_BR = 7'b0000110;
  localparam logic [6:0] C_MW = 7'b1111001;

  localparam logic [1:0] RF = 2'b10;
  localparam logic [1:0] MM = 2'b01;
  localparam logic [1:0] WB = 2'b00;

  localparam logic [1:0] E0 = 2'b00;
  localparam logic [1:0] E1 = 2'b01;
  localparam logic [1:0] EX = 2'b10;

  localparam logic [18:0] NOP = '0;

  function automatic logic [18:0] alu(
    input int rd, input int rs1, input int rs2);
    return {1'b1, rs1[4:0], rs2[4:0], rd[4:0], 3'b100};
  endfunction

  function automatic logic [18:0] lw(
    input int rd, input int rs1);
    return {1'b1, rs1[4:0], 5'd0, rd[4:0], 3'b111};
  endfunction

  function automatic logic [18:0] sw(
    input int rs1, input int rs2);
    return {1'b1, rs1[4:0], rs2[4:0], 5'd0, 3'b001};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [18:0] ins,
                       input logic br,
                       input logic rdy);
    {hz_if.id_valid, hz_if.id_rs1, hz_if.id_rs2,
     hz_if.id_rd, hz_if.id_regwrite, hz_if.id_is_load,
     hz_if.id_is_mem} = ins;
    hz_if.ex_branch_taken = br;
    hz_if.dmem_ready      = rdy;
  endtask

  task automatic push(input string nm,
                      input logic [6:0] ctl,
                      input logic [1:0] fa,
                      input logic [1:0] fb,
                      input logic [1:0] err);
    exp_t e;
    e.nm  = nm;
    e.ctl = ctl;
    e.fa  = fa;
    e.fb  = fb;
    e.err = err;
    sbq.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    logic [6:0] ctl;
    if (sbq.size() == 0) begin
      chk("sbq underflow", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    ctl = {hz_if.stall_if, hz_if.stall_id,
           hz_if.stall_ex, hz_if.stall_mem,
           hz_if.bubble_ex, hz_if.flush_if_id,
           hz_if.bubble_wb};
    chk({e.nm, " ctl"}, 32'(ctl), 32'(e.ctl));
    chk({e.nm, " fwdA"}, 32'(hz_if.forwardA), 32'(e.fa));
    chk({e.nm, " fwdB"}, 32'(hz_if.forwardB), 32'(e.fb));
    if (!e.err[1])
      chk({e.nm, " err"}, 32'(hz_if.mem_timeout_err),
          32'(e.err[0]));
  endtask

  task automatic cyc(input string nm,
                     input logic [18:0] ins,
                     input logic br,
                     input logic rdy,
                     input logic [6:0] ctl,
                     input logic [1:0] fa,
                     input logic [1:0] fb,
                     input logic [1:0] err);
    drive(ins, br, rdy);
    push(nm, ctl, fa, fb, err);
    @(negedge clk);
    score();
    @(posedge clk);
    #1;
  endtask

  task automatic perf(input string nm,
                      input int lu,
                      input int mw,
                      input int fl);
`ifdef HAZARD_PERF_CNT_EN
    chk({nm, " perf_lu"}, hz_if.perf_lu_stalls, lu);
    chk({nm, " perf_mw"}, hz_if.perf_mem_wait_cycles, mw);
    chk({nm, " perf_fl"}, hz_if.perf_flushes, fl);
`else
    if (lu + mw + fl < 0) $display("%s", nm);
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive(NOP, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    push("rst", C_0, RF, RF, E0);
    score();
    perf("rst", 0, 0, 0);
    rst = 1'b0;

    // back-to-back, one gap, and x0 destination
    cyc("a1",  alu(5, 1, 2), 0, 1, C_0, RF, RF, E0);
    cyc("a2",  alu(6, 5, 5), 0, 1, C_0, RF, RF, E0);
    cyc("a3",  NOP,          0, 1, C_0, MM, MM, E0);
    cyc("a4",  NOP,          0, 1, C_0, RF, RF, E0);
    cyc("a5",  alu(5, 1, 2), 0, 1, C_0, RF, RF, E0);
    cyc("a6",  NOP,          0, 1, C_0, RF, RF, E0);
    cyc("a7",  alu(6, 5, 5), 0, 1, C_0, RF, RF, E0);
    cyc("a8",  NOP,          0, 1, C_0, WB, WB, E0);
    cyc("a9",  alu(0, 1, 2), 0, 1, C_0, RF, RF, E0);
    cyc("a10", alu(6, 0, 0), 0, 1, C_0, RF, RF, E0);
    cyc("a11", NOP,          0, 1, C_0, RF, RF, E0);
    cyc("a12", NOP,          0, 1, C_0, RF, RF, E0);
    cyc("a13", NOP,          0, 1, C_0, RF, RF, E0);

    // MEM beats WB when both write the same rd
    cyc("p1", alu(5, 1, 2), 0, 1, C_0, RF, RF, E0);
    cyc("p2", alu(5, 3, 4), 0, 1, C_0, RF, RF, E0);
    cyc("p3", alu(6, 5, 5), 0, 1, C_0, RF, RF, E0);
    cyc("p4", NOP,          0, 1, C_0, MM, MM, E0);
    cyc("p5", NOP,          0, 1, C_0, RF, RF, E0);
    cyc("p6", NOP,          0, 1, C_0, RF, RF, E0);

    // rs1 from MEM, rs2 from WB
    cyc("m1", alu(5, 1, 2), 0, 1, C_0, RF, RF, E0);
    cyc("m2", alu(9, 1, 2), 0, 1, C_0, RF, RF, E0);
    cyc("m3", alu(6, 9, 5), 0, 1, C_0, RF, RF, E0);
    cyc("m4", NOP,          0, 1, C_0, MM, WB, E0);
    cyc("m5", NOP,          0, 1, C_0, RF, RF, E0);
    cyc("m6", NOP,          0, 1, C_0, RF, RF, E0);

    // load-use: one stall, then WB bypass
    cyc("l1", lw(7, 1),     0, 1, C_0,  RF, RF, E0);
    cyc("l2", alu(8, 7, 1), 0, 1, C_LU, RF, RF, E0);
    cyc("l3", alu(8, 7, 1), 0, 1, C_0,  RF, RF, E0);
    cyc("l4", NOP,          0, 1, C_0,  WB, RF, E0);
    cyc("l5", NOP,          0, 1, C_0,  RF, RF, E0);
    cyc("l6", NOP,          0, 1, C_0,  RF, RF, E0);

    // taken branch overrides load-use
    cyc("b1", lw(7, 1),     0, 1, C_0,  RF, RF, E0);
    cyc("b2", alu(8, 7, 1), 1, 1, C_BR, RF, RF, E0);
    cyc("b3", NOP,          0, 1, C_0,  RF, RF, E0);
    cyc("b4", NOP,          0, 1, C_0,  RF, RF, E0);
    cyc("b5", NOP,          0, 1, C_0,  RF, RF, E0);

    // three-cycle data memory wait
    cyc("w1", sw(1, 2), 0, 1, C_0,  RF, RF, E0);
    cyc("w2", NOP,      0, 1, C_0,  RF, RF, E0);
    cyc("w3", NOP,      0, 0, C_MW, RF, RF, E0);
    cyc("w4", NOP,      0, 0, C_MW, RF, RF, E0);
    cyc("w5", NOP,      0, 0, C_MW, RF, RF, E0);
    cyc("w6", NOP,      0, 1, C_0,  RF, RF, E0);
    cyc("w7", NOP,      0, 1, C_0,  RF, RF, E0);
    perf("scen", 1, 3, 1);

    // six-cycle wait crosses MEM_TIMEOUT=4
    cyc("t1",  sw(1, 2), 0, 1, C_0,  RF, RF, E0);
    cyc("t2",  NOP,      0, 1, C_0,  RF, RF, E0);
    cyc("t3",  NOP,      0, 0, C_MW, RF, RF, E0);
    cyc("t4",  NOP,      0, 0, C_MW, RF, RF, E0);
    cyc("t5",  NOP,      0, 0, C_MW, RF, RF, E0);
    cyc("t6",  NOP,      0, 0, C_MW, RF, RF, EX);
    cyc("t7",  NOP,      0, 0, C_MW, RF, RF, E1);
    cyc("t8",  NOP,      0, 0, C_MW, RF, RF, E1);
    cyc("t9",  NOP,      0, 1, C_0,  RF, RF, E1);
    cyc("t10", NOP,      0, 1, C_0,  RF, RF, E1);
    perf("tmo", 1, 9, 1);

    // async reset in the middle of a wait (counter at 5)
    cyc("r1", sw(1, 2), 0, 1, C_0,  RF, RF, E1);
    cyc("r2", NOP,      0, 1, C_0,  RF, RF, E1);
    cyc("r3", NOP,      0, 0, C_MW, RF, RF, E1);
    cyc("r4", NOP,      0, 0, C_MW, RF, RF, E1);
    cyc("r5", NOP,      0, 0, C_MW, RF, RF, E1);
    cyc("r6", NOP,      0, 0, C_MW, RF, RF, E1);
    cyc("r7", NOP,      0, 0, C_MW, RF, RF, E1);
    push("r8", C_MW, RF, RF, E1);
    score();
    #2;
    rst = 1'b1;
    #1;
    push("rstmw", C_0, RF, RF, E0);
    score();
    perf("rstmw", 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("r9",  NOP,          0, 0, C_0, RF, RF, E0);
    cyc("r10", alu(5, 1, 2), 0, 0, C_0, RF, RF, E0);
    cyc("r11", NOP,          0, 0, C_0, RF, RF, E0);

    chk("sbq drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
